sla_seq: RTL
============

SLA_SEQ -- requirements
Module: sla_seq

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and result.
REQ-002 Parameter AMT_W, default 5, width of the shift-amount fields.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 operation request; held high until gnt[0] is seen.
REQ-006 a0  input  WIDTH  requester 0 operand.
REQ-007 amt0  input  AMT_W  requester 0 shift amount, 0..31.
REQ-008 req1  input  1  requester 1 operation request; same rules as req0.
REQ-009 a1  input  WIDTH  requester 1 operand.
REQ-010 amt1  input  AMT_W  requester 1 shift amount.
REQ-011 gnt  output  2  one-hot registered grant pulse; bit i means requester i was accepted.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle result-valid pulse.
REQ-014 done_id  output  1  requester index owning the current or last result.
REQ-015 out  output  WIDTH  registered result; holds until the next done.
REQ-016 ovf  output  1  arithmetic overflow flag for the current or last result.

Function
REQ-017 FSM states are IDLE, SHIFT and DONE; the shared shift-left-by-one datapath is used iteratively, one doubling per SHIFT cycle.
REQ-018 In IDLE, when any req is high at an edge, the block accepts one request: it latches operand, amount and id, clears ovf, and loads the accumulator with the operand.
REQ-019 Arbitration: a lone request wins; on a tie, the requester not served last wins (round-robin pointer last_id, updated on each acceptance).
REQ-020 gnt is high for exactly the one cycle following the acceptance edge, with only the accepted bit set; otherwise gnt=00.
REQ-021 After acceptance, the next state is SHIFT if the amount is nonzero, otherwise DONE.
REQ-022 Each SHIFT edge: acc <= acc*2 truncated to WIDTH bits, and remaining count decrements; ovf is set (sticky) if acc[WIDTH-1] != acc[WIDTH-2] before that step.
REQ-023 When the step consuming the last count occurs, the next state is DONE; an amount of N therefore spends exactly N cycles in SHIFT.
REQ-024 On entering DONE, out <= acc and done_id <= latched id; done=1 for that single DONE cycle, then state returns to IDLE.
REQ-025 Latency: with amount N, done is high in cycle N+1 after the acceptance edge; throughput is one operation per N+2 cycles.
REQ-026 Requests arriving while busy=1 are ignored (no gnt) and are arbitrated at the first IDLE edge in which they are still asserted.
REQ-027 Input changes on a, amt or req after acceptance do not affect the in-flight operation.
REQ-028 Bits shifted out of the MSB are discarded; no saturation is applied.

Reset
REQ-029 On reset: state=IDLE, out=0, ovf=0, done=0, done_id=0, gnt=00, busy=0, and last_id=1 so that requester 0 wins the first tie.
REQ-030 Reset asserted mid-operation abandons the operation with no done pulse; reset has priority over all other transitions.

Verification
REQ-031 req0, a0=0x00000003, amt0=4 -> gnt=01 one cycle after acceptance; done in cycle 5; out=0x00000030, done_id=0, ovf=0.
REQ-032 req1, a1=0x12345678, amt1=0 -> done in the cycle after acceptance; out=0x12345678, done_id=1, ovf=0.
REQ-033 req0 and req1 high together from reset and both held -> requester 0 is served first, then requester 1; on the next simultaneous pair after that, requester 0 is served first again (pointer alternates).
REQ-034 a=0x40000000, amt=1 -> out=0x80000000, ovf=1; a=0xC0000000, amt=1 -> out=0x80000000, ovf=0.
REQ-035 a=0x00000001, amt=31 -> busy for 32 cycles; out=0x80000000, ovf=1.
REQ-036 reset pulsed during SHIFT -> no done, all outputs at reset values; the next request completes normally with correct result.

Source files
------------

// File: rtl/sla_seq.sv
// sla_seq: two-requester arbitrated shift-left unit.
// A single shift-by-one datapath is reused once per SHIFT cycle, so an
// amount of N takes N SHIFT cycles plus one DONE cycle. Overflow is sticky
// and is raised whenever a step would change the sign bit.
module sla_seq #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [AMT_W-1:0] amt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [AMT_W-1:0] amt1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic             id_reg, id_next;
  logic             last_id_reg, last_id_next;
  logic [1:0]       gnt_reg, gnt_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             ovf_reg, ovf_next;
  logic             done_id_reg, done_id_next;

  // Arbitration and datapath helpers
  logic             sel;
  logic [WIDTH-1:0] sel_a;
  logic [AMT_W-1:0] sel_amt;
  logic [WIDTH-1:0] shifted;

  // State register and datapath registers; reset abandons any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      id_reg      <= 1'b0;
      last_id_reg <= 1'b1;   // requester 0 wins the first tie
      gnt_reg     <= 2'b00;
      out_reg     <= '0;
      ovf_reg     <= 1'b0;
      done_id_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      id_reg      <= id_next;
      last_id_reg <= last_id_next;
      gnt_reg     <= gnt_next;
      out_reg     <= out_next;
      ovf_reg     <= ovf_next;
      done_id_reg <= done_id_next;
    end
  end

  // Next-state, arbitration and one shift step per SHIFT cycle
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    id_next      = id_reg;
    last_id_next = last_id_reg;
    gnt_next     = 2'b00;
    out_next     = out_reg;
    ovf_next     = ovf_reg;
    done_id_next = done_id_reg;

    // On a tie the requester not served last wins; otherwise the lone one.
    sel     = (req0 && req1) ? ~last_id_reg : req1;
    sel_a   = sel ? a1 : a0;
    sel_amt = sel ? amt1 : amt0;
    shifted = {acc_reg[WIDTH-2:0], 1'b0};

    unique case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          acc_next     = sel_a;
          cnt_next     = sel_amt;
          id_next      = sel;
          last_id_next = sel;
          ovf_next     = 1'b0;
          gnt_next     = sel ? 2'b10 : 2'b01;
          if (sel_amt == '0) begin
            // Zero amount: result is the operand itself, published next cycle
            state_next   = DONE;
            out_next     = sel_a;
            done_id_next = sel;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_next = shifted;
        cnt_next = cnt_reg - AMT_W'(1);
        if (acc_reg[WIDTH-1] != acc_reg[WIDTH-2]) begin
          ovf_next = 1'b1;
        end
        if (cnt_reg == AMT_W'(1)) begin
          // Last step: the result register is loaded as DONE is entered
          state_next   = DONE;
          out_next     = shifted;
          done_id_next = id_reg;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt     = gnt_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign done_id = done_id_reg;
  assign out     = out_reg;
  assign ovf     = ovf_reg;

endmodule
